// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the nonce-search micro-hash engine.
package hash_pkg;

    localparam logic [7:0] INIT_A    = 8'h01;
    localparam logic [7:0] INIT_B    = 8'h89;
    localparam logic [7:0] INIT_C    = 8'hFE;
    localparam logic [7:0] K_LO      = 8'h99;
    localparam logic [7:0] K_HI      = 8'hA1;
    localparam int         ROUNDS    = 32;
    localparam int         HDR_BYTES = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/hash_round.sv
// One combinational micro-hash round; rounds 16..31 use K_HI and fold c into x.
module hash_round
    import hash_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_c,
    input  logic [7:0] i_w,
    input  logic [4:0] i_idx,
    output logic [7:0] o_a,
    output logic [7:0] o_b,
    output logic [7:0] o_c
);

    logic       w_hi;
    logic [7:0] w_x;
    logic [7:0] w_k;

    assign w_hi = i_idx[4];
    assign w_x  = w_hi ? (i_a ^ i_b ^ i_c) : (i_a ^ i_b);
    assign w_k  = w_hi ? K_HI : K_LO;

    assign o_a = i_b ^ i_c;
    assign o_b = {i_c[3:0], 4'b0000};
    assign o_c = w_x + w_k + i_w;

endmodule

// File: rtl/hash_nonce_search.sv
// Nonce search: hashes header||nonce with UNROLL rounds/clock until both upper hash bytes pass target.
// Optional best-hash tracking outputs are built when HASH_BEST_TRACK_EN is defined.
module hash_nonce_search
    import hash_pkg::*;
#(
    parameter int          UNROLL    = 1,
    parameter logic [31:0] MAX_NONCE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [95:0] block_in,
    input  logic [8:0]  target,
    output logic [23:0] hash_out,
    output logic [31:0] nonce_out,
    output logic        valid,
    output logic        not_found,
    output logic        busy,
`ifdef HASH_BEST_TRACK_EN
    output logic [23:0] best_hash,
    output logic [31:0] best_nonce,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - UNROLL);

    state_t       r_state;
    state_t       w_next;
    logic [95:0]  r_hdr;
    logic [8:0]   r_tgt;
    logic [31:0]  r_nonce;
    logic [7:0]   r_a;
    logic [7:0]   r_b;
    logic [7:0]   r_c;
    logic [127:0] r_win;
    logic [4:0]   r_rnd;
    logic [23:0]  r_hash;
    logic [31:0]  r_nonce_out;
    logic [127:0] w_msg;
    logic [7:0]   w_h0;
    logic [7:0]   w_h1;
    logic [7:0]   w_h2;
    logic         w_pass;

    // Window byte j holds W[i+j] for the round about to be evaluated.
    logic [7:0]   w_a   [UNROLL+1];
    logic [7:0]   w_b   [UNROLL+1];
    logic [7:0]   w_c   [UNROLL+1];
    logic [127:0] w_win [UNROLL+1];

    assign w_a[0]   = r_a;
    assign w_b[0]   = r_b;
    assign w_c[0]   = r_c;
    assign w_win[0] = r_win;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        hash_round u_round (
            .i_a  (w_a[g]),
            .i_b  (w_b[g]),
            .i_c  (w_c[g]),
            .i_w  (w_win[g][7:0]),
            .i_idx(r_rnd + 5'(g)),
            .o_a  (w_a[g+1]),
            .o_b  (w_b[g+1]),
            .o_c  (w_c[g+1])
        );
        assign w_win[g+1] = {w_win[g][111:104] | (w_win[g][63:56] ^ w_win[g][23:16]),
                             w_win[g][127:8]};
    end

    always_comb begin
        w_msg = '0;
        for (int j = 0; j < HDR_BYTES; j++) begin
            w_msg[8*j +: 8] = r_hdr[95-8*j -: 8];
        end
        for (int j = 0; j < 4; j++) begin
            w_msg[8*(HDR_BYTES+j) +: 8] = r_nonce[31-8*j -: 8];
        end
    end

    assign w_h0   = INIT_A + r_a;
    assign w_h1   = INIT_B + r_b;
    assign w_h2   = INIT_C + r_c;
    assign w_pass = ({1'b0, w_h0} < r_tgt) && ({1'b0, w_h1} < r_tgt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (ready) w_next = ST_LOAD;
            ST_LOAD:  w_next = ready ? ST_ROUND : ST_IDLE;
            ST_ROUND: begin
                if (!ready)                 w_next = ST_IDLE;
                else if (r_rnd == LAST_RND) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (!ready)                      w_next = ST_IDLE;
                else if (w_pass)                 w_next = ST_DONE;
                else if (r_nonce == MAX_NONCE)   w_next = ST_FAIL;
                else                             w_next = ST_LOAD;
            end
            ST_DONE, ST_FAIL: if (!ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hdr       <= '0;
            r_tgt       <= '0;
            r_nonce     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_win       <= '0;
            r_rnd       <= '0;
            r_hash      <= '0;
            r_nonce_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (ready) begin
                    r_hdr   <= block_in;
                    r_tgt   <= target;
                    r_nonce <= '0;
                end
                ST_LOAD: begin
                    r_a   <= INIT_A;
                    r_b   <= INIT_B;
                    r_c   <= INIT_C;
                    r_win <= w_msg;
                    r_rnd <= '0;
                end
                ST_ROUND: begin
                    r_a   <= w_a[UNROLL];
                    r_b   <= w_b[UNROLL];
                    r_c   <= w_c[UNROLL];
                    r_win <= w_win[UNROLL];
                    r_rnd <= r_rnd + 5'(UNROLL);
                end
                ST_CHECK: if (ready) begin
                    if (w_pass) begin
                        r_hash      <= {w_h0, w_h1, w_h2};
                        r_nonce_out <= r_nonce;
                    end else if (r_nonce != MAX_NONCE) begin
                        r_nonce <= r_nonce + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HASH_BEST_TRACK_EN
    logic [23:0] r_best_hash;
    logic [31:0] r_best_nonce;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_best_hash  <= 24'hFF_FFFF;
            r_best_nonce <= '0;
        end else if (r_state == ST_IDLE && ready) begin
            r_best_hash  <= 24'hFF_FFFF;
            r_best_nonce <= '0;
        end else if (r_state == ST_CHECK && ready && ({w_h0, w_h1} < r_best_hash[23:8])) begin
            r_best_hash  <= {w_h0, w_h1, w_h2};
            r_best_nonce <= r_nonce;
        end
    end

    assign best_hash  = r_best_hash;
    assign best_nonce = r_best_nonce;
`endif

    // Status flags decode the state register so an async reset clears them at once.
    assign valid     = (r_state == ST_DONE);
    assign not_found = (r_state == ST_FAIL);
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_ROUND) || (r_state == ST_CHECK);
    assign hash_out  = r_hash;
    assign nonce_out = r_nonce_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_hash_nonce_search.sv
// Bench for hash_nonce_search: four instances (UNROLL 1/8/4/1, MAX_NONCE default/default/3/15)
// against a reference model of the micro-hash; best-hash outputs checked under HASH_BEST_TRACK_EN.
module tb_hash_nonce_search;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] block_in;
    logic [8:0]  target;
    logic        rdy0, rdy1, rdy2, rdy3;
    logic [23:0] h0, h1, h2, h3;
    logic [31:0] n0, n1, n2, n3;
    logic        v0, v1, v2, v3;
    logic        nf0, nf1, nf2, nf3;
    logic        b0, b1, b2, b3;
    logic [2:0]  st0, st1, st2, st3;
`ifdef HASH_BEST_TRACK_EN
    logic [23:0] bh0, bh1, bh2, bh3;
    logic [31:0] bn0, bn1, bn2, bn3;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] last_h [4];
    logic [31:0] last_n [4];

    always #5 clk = ~clk;

    hash_nonce_search #(.UNROLL(1)) u_dut0 (
        .clk(clk), .reset(reset), .ready(rdy0), .block_in(block_in), .target(target),
        .hash_out(h0), .nonce_out(n0), .valid(v0), .not_found(nf0), .busy(b0),
`ifdef HASH_BEST_TRACK_EN
        .best_hash(bh0), .best_nonce(bn0),
`endif
        .dbg_state(st0));

    hash_nonce_search #(.UNROLL(8)) u_dut1 (
        .clk(clk), .reset(reset), .ready(rdy1), .block_in(block_in), .target(target),
        .hash_out(h1), .nonce_out(n1), .valid(v1), .not_found(nf1), .busy(b1),
`ifdef HASH_BEST_TRACK_EN
        .best_hash(bh1), .best_nonce(bn1),
`endif
        .dbg_state(st1));

    hash_nonce_search #(.UNROLL(4), .MAX_NONCE(32'd3)) u_dut2 (
        .clk(clk), .reset(reset), .ready(rdy2), .block_in(block_in), .target(target),
        .hash_out(h2), .nonce_out(n2), .valid(v2), .not_found(nf2), .busy(b2),
`ifdef HASH_BEST_TRACK_EN
        .best_hash(bh2), .best_nonce(bn2),
`endif
        .dbg_state(st2));

    hash_nonce_search #(.UNROLL(1), .MAX_NONCE(32'd15)) u_dut3 (
        .clk(clk), .reset(reset), .ready(rdy3), .block_in(block_in), .target(target),
        .hash_out(h3), .nonce_out(n3), .valid(v3), .not_found(nf3), .busy(b3),
`ifdef HASH_BEST_TRACK_EN
        .best_hash(bh3), .best_nonce(bn3),
`endif
        .dbg_state(st3));

    function automatic logic [23:0] mhash(input logic [95:0] hdr, input logic [31:0] n);
        logic [7:0] m [32];
        logic [7:0] a, b, c, x, k, na, nb, nc;
        for (int i = 0; i < 12; i++) m[i] = hdr[95-8*i -: 8];
        for (int i = 0; i < 4; i++)  m[12+i] = n[31-8*i -: 8];
        for (int i = 16; i < 32; i++) m[i] = m[i-3] | (m[i-9] ^ m[i-14]);
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) begin k = 8'h99; x = a ^ b; end
            else        begin k = 8'hA1; x = a ^ b ^ c; end
            na = b ^ c;
            nb = c << 4;
            nc = x + k + m[i];
            a = na; b = nb; c = nc;
        end
        return {8'h01 + a, 8'h89 + b, 8'hFE + c};
    endfunction

    function automatic bit passes(input logic [23:0] h, input logic [8:0] tgt);
        return ({1'b0, h[23:16]} < tgt) && ({1'b0, h[15:8]} < tgt);
    endfunction

    task automatic model_search(input logic [95:0] hdr, input logic [8:0] tgt, input int limit,
                                output bit found, output logic [31:0] en, output logic [23:0] eh);
        found = 0; en = 0; eh = 0;
        for (int n = 0; n < limit; n++) begin
            eh = mhash(hdr, 32'(n));
            if (passes(eh, tgt)) begin
                found = 1; en = 32'(n);
                break;
            end
        end
    endtask

    task automatic pick_header(input logic [8:0] tgt, output logic [95:0] hdr);
        bit found;
        logic [31:0] en;
        logic [23:0] eh;
        do begin
            hdr = {$urandom, $urandom, $urandom};
            model_search(hdr, tgt, 64, found, en, eh);
        end while (!found);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rdy(input int idx, input logic val);
        case (idx)
            0: rdy0 = val;
            1: rdy1 = val;
            2: rdy2 = val;
            default: rdy3 = val;
        endcase
    endtask

    task automatic rd(input int idx, output logic v, output logic nf, output logic bz,
                      output logic [23:0] h, output logic [31:0] n);
        case (idx)
            0: begin v = v0; nf = nf0; bz = b0; h = h0; n = n0; end
            1: begin v = v1; nf = nf1; bz = b1; h = h1; n = n1; end
            2: begin v = v2; nf = nf2; bz = b2; h = h2; n = n2; end
            default: begin v = v3; nf = nf3; bz = b3; h = h3; n = n3; end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        logic v, nf, bz;
        logic [23:0] h;
        logic [31:0] n;
        for (int i = 0; i < 4; i++) begin
            rd(i, v, nf, bz, h, n);
            check($sformatf("%s_valid%0d", tag, i), 64'(v), 64'(0));
            check($sformatf("%s_nf%0d", tag, i), 64'(nf), 64'(0));
            check($sformatf("%s_busy%0d", tag, i), 64'(bz), 64'(0));
            check($sformatf("%s_hash%0d", tag, i), 64'(h), 64'(0));
            check($sformatf("%s_nonce%0d", tag, i), 64'(n), 64'(0));
            last_h[i] = '0;
            last_n[i] = '0;
        end
    endtask

    // limit = number of nonces the instance may try (MAX_NONCE+1, or a search cap for headers known to hit).
    task automatic run(input int idx, input int rr, input int limit, input logic [95:0] hdr,
                       input logic [8:0] tgt, input bit drop);
        bit found;
        logic [31:0] en;
        logic [23:0] eh;
        int exp_cyc, cyc;
        logic v, nf, bz;
        logic [23:0] h;
        logic [31:0] n;
        model_search(hdr, tgt, limit, found, en, eh);
        exp_cyc = found ? (int'(en) + 1) * (rr + 2) : limit * (rr + 2);
        @(negedge clk);
        block_in = hdr; target = tgt; set_rdy(idx, 1'b1);
        @(posedge clk);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            rd(idx, v, nf, bz, h, n);
        end while (!v && !nf && cyc < exp_cyc + 20);
        check($sformatf("latency%0d", idx), 64'(cyc), 64'(exp_cyc));
        check($sformatf("valid%0d", idx), 64'(v), 64'(found));
        check($sformatf("not_found%0d", idx), 64'(nf), 64'(!found));
        if (found) begin
            last_h[idx] = eh;
            last_n[idx] = en;
        end
        check($sformatf("hash%0d", idx), 64'(h), 64'(last_h[idx]));
        check($sformatf("nonce%0d", idx), 64'(n), 64'(last_n[idx]));
        if (drop) begin
            @(negedge clk);
            set_rdy(idx, 1'b0);
            @(posedge clk); #1;
            rd(idx, v, nf, bz, h, n);
            check($sformatf("clr_valid%0d", idx), 64'(v), 64'(0));
            check($sformatf("clr_nf%0d", idx), 64'(nf), 64'(0));
            check($sformatf("clr_busy%0d", idx), 64'(bz), 64'(0));
            check($sformatf("keep_hash%0d", idx), 64'(h), 64'(last_h[idx]));
            check($sformatf("keep_nonce%0d", idx), 64'(n), 64'(last_n[idx]));
        end
    endtask

    initial begin
        logic [95:0] hdr, hdr_b;
        logic [8:0]  tgt;
        logic v, nf, bz;
        logic [23:0] h, best_h;
        logic [31:0] n, best_n;

        reset = 1'b0; block_in = '0; target = '0;
        rdy0 = 0; rdy1 = 0; rdy2 = 0; rdy3 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
`ifdef HASH_BEST_TRACK_EN
        check("rst_best_hash", 64'(bh3), 64'(24'hFF_FFFF));
        check("rst_best_nonce", 64'(bn3), 64'(0));
`endif
        @(negedge clk) reset = 1'b1;

        // Every nonce passes with target 0x100: first result after 34 cycles at nonce 0.
        pick_header(9'h100, hdr);
        run(0, 32, 64, hdr, 9'h100, 1);

        // Target 0 never passes: exhaust nonces 0..3.
        hdr = {$urandom, $urandom, $urandom};
        run(2, 8, 4, hdr, 9'h000, 1);

        // Same header through UNROLL=1 and UNROLL=8.
        pick_header(9'h040, hdr);
        run(0, 32, 64, hdr, 9'h040, 1);
        run(1, 4, 64, hdr, 9'h040, 1);

        // Abort in ROUND cycle 10, two low cycles, restart with a new header.
        pick_header(9'h040, hdr);
        pick_header(9'h040, hdr_b);
        @(negedge clk);
        block_in = hdr; target = 9'h040; rdy0 = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk) rdy0 = 1'b0;
        @(posedge clk); #1;
        rd(0, v, nf, bz, h, n);
        check("abort_busy", 64'(bz), 64'(0));
        check("abort_valid", 64'(v), 64'(0));
        check("abort_hash", 64'(h), 64'(last_h[0]));
        check("abort_nonce", 64'(n), 64'(last_n[0]));
        @(posedge clk);
        run(0, 32, 64, hdr_b, 9'h040, 1);

        // Random targets on the UNROLL=8 instance.
        for (int it = 0; it < 3; it++) begin
            tgt = 9'($urandom_range(32, 256));
            pick_header(tgt, hdr);
            run(1, 4, 64, hdr, tgt, 1);
        end

        // Asynchronous reset in the middle of ROUND.
        pick_header(9'h040, hdr);
        @(negedge clk);
        block_in = hdr; target = 9'h040; rdy1 = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("rst_round");
        rdy1 = 1'b0;
        @(negedge clk) reset = 1'b1;

        // Asynchronous reset while DONE is held.
        pick_header(9'h100, hdr);
        run(0, 32, 64, hdr, 9'h100, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", 64'(v0), 64'(1));
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("rst_done");
        rdy0 = 1'b0;
        @(negedge clk) reset = 1'b1;

        pick_header(9'h040, hdr);
        run(0, 32, 64, hdr, 9'h040, 1);

        // Exhaust nonces 0..15 and compare the running minimum.
        hdr = {$urandom, $urandom, $urandom};
        run(3, 32, 16, hdr, 9'h000, 1);
        best_h = 24'hFF_FFFF;
        best_n = '0;
        for (int k = 0; k < 16; k++) begin
            h = mhash(hdr, 32'(k));
            if (h[23:8] < best_h[23:8]) begin
                best_h = h;
                best_n = 32'(k);
            end
        end
`ifdef HASH_BEST_TRACK_EN
        check("best_hash", 64'(bh3), 64'(best_h));
        check("best_nonce", 64'(bn3), 64'(best_n));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hash_nonce_search.md
Name: hash_nonce_search

Overview:
- Parametrised successor to the fixed 16-byte micro-hash block.
- Takes a 12-byte block header and a target. Iterates a 32-bit nonce, computing the 24-bit micro-hash of header‖nonce with UNROLL rounds per clock.
- Stops on the first nonce whose two upper hash bytes are below the target.
- Sits between the header/control source and the result collector.

Parameters:
- UNROLL, 1, hash rounds evaluated per clock; legal values 1, 2, 4, 8, 16, 32.
- MAX_NONCE, 32'hFFFF_FFFF, last nonce tried before declaring not_found.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ready  input  1  level request; high = search enabled, low = abort or acknowledge.
- block_in  input  96  header bytes M[0..11]; M[0] = block_in[95:88].
- target  input  9  unsigned threshold; a byte b passes when {1'b0,b} < target.
- hash_out  output  24  final hash {H0,H1,H2} of the reported nonce.
- nonce_out  output  32  nonce that produced hash_out.
- valid  output  1  result found, held until ready is low.
- not_found  output  1  nonce range exhausted, held until ready is low.
- busy  output  1  high in LOAD/ROUND/CHECK.

Behaviour:
- Message M[0..15]: M[0..11] from the header latched at start; M[12..15] = nonce, big-endian.
- Schedule: W[i]=M[i] for i<16; W[i]=W[i-3] | (W[i-9] ^ W[i-14]) for 16≤i<32, all 8-bit. Implemented as a 16-byte sliding window.
- Init: a=8'h01, b=8'h89, c=8'hFE.
- Round i, for i<16: k=8'h99, x=a^b. For i≥16: k=8'hA1, x=a^b^c.
- Round update: a'=b^c; b'=c<<4 (8-bit); c'=x+k+W[i] mod 256.
- Final hash: H0=8'h01+a, H1=8'h89+b, H2=8'hFE+c, each mod 256.
- Pass condition: H0 and H1 both pass against target.
- FSM states: IDLE, LOAD, ROUND, CHECK, DONE, FAIL.
- IDLE: on ready=1, latch block_in and target, nonce←0, go to LOAD. block_in and target are ignored after the latch.
- LOAD (1 cycle): initialise a/b/c, window and round counter.
- ROUND (R=32/UNROLL cycles): at the last round cycle, go to CHECK.
- CHECK (1 cycle): on pass, register hash_out and nonce_out, go to DONE. Else if nonce==MAX_NONCE, go to FAIL. Else nonce+1, go to LOAD.
- Timing: valid rises (n+1)(R+2) cycles after the edge that sampled ready, where n = winning nonce.
- DONE/FAIL: valid or not_found held high. ready low returns to IDLE on the next edge, and valid/not_found clear in the same cycle.
- ready low in LOAD/ROUND/CHECK: abort to IDLE next edge; hash_out and nonce_out keep their old values.
- ready held high in DONE/FAIL: stays there; no re-arm until ready is observed low in IDLE.
- Nonce never wraps: MAX_NONCE=FFFF_FFFF stops in FAIL.
- Reset (asynchronous, any state): state=IDLE; hash_out=0, nonce_out=0, valid=0, not_found=0, busy=0.

Optional Feature:
- Macro: HASH_BEST_TRACK_EN.
- Defined: adds outputs best_hash[23:0] and best_nonce[31:0].
  - Updated in CHECK when {H0,H1} is strictly less than the stored value.
  - Cleared to 24'hFFFFFF / 0 at reset and on each IDLE→LOAD.
- Undefined: the ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package hash_pkg holds: init constants 8'h01/8'h89/8'hFE, K_LO=8'h99, K_HI=8'hA1, ROUNDS=32, HDR_BYTES=12, and the state enum.
- Sub-module hash_round: purely combinational single round with inputs a, b, c, w, round index and outputs a', b', c'.
- Top instantiates UNROLL copies of hash_round in a generate chain.

Test Plan:
- UNROLL=1, target=9'h100, any header: valid at cycle 34, nonce_out=0, hash_out equals the bit-exact model.
- UNROLL=4, MAX_NONCE=3, target=0: not_found at cycle 4·10=40, valid stays 0; ready low → IDLE, not_found=0 next cycle.
- UNROLL=1 and UNROLL=8, same header with target=9'h040: identical nonce_out/hash_out versus model; latencies (n+1)·34 and (n+1)·6.
- ready dropped at ROUND cycle 10, then raised two cycles later: restart from nonce 0 with the new block_in latched; result matches the model.
- reset asserted mid-ROUND and mid-DONE: all outputs 0 immediately, without waiting for a clock edge; normal search resumes after release.
- HASH_BEST_TRACK_EN, MAX_NONCE=15, target=0: not_found; best_hash/best_nonce equal the model's minimum over nonces 0..15.
